muxn_pipe: RTL
==============

Name: muxn_pipe

Overview:
- Parametrised N-input, WIDTH-bit selector with a registered, valid/ready-handshaked output stage.
- Successor to the fixed 32-bit 3:1 write-back mux. Used wherever the datapath selects between result sources, e.g. write-back (ALU / memory / PC+4 / CSR) in the pipelined core.
- Adds out-of-range select detection, a 2-entry skid buffer for full throughput under backpressure, and a saturating select-error counter.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 3, number of inputs; legal range 2..16.
- SEL_W, $clog2(NUM_IN), select width; derived, never overridden.
- ERR_CNT_W, 8, width of the saturating select-error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NUM_IN*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH].
- in_sel  in  SEL_W  select for the current transfer.
- in_valid  in  1  upstream offers in_data/in_sel.
- in_ready  out  1  block accepts a transfer this cycle.
- out_data  out  WIDTH  selected data.
- out_sel_err  out  1  the out_data beat was produced from an out-of-range select.
- out_valid  out  1  out_data/out_sel_err are valid.
- out_ready  in  1  downstream accepts the output beat.
- err_cnt  out  ERR_CNT_W  count of accepted beats with out-of-range select; saturates.
- err_cnt_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_sel_err=0, err_cnt=0.
  - Both buffer entries invalid; state EMPTY; in_ready=1.
- Selection (combinational, ahead of the registers):
  - in_sel < NUM_IN selects input in_sel.
  - in_sel >= NUM_IN selects input NUM_IN-1 and sets the beat's sel_err bit. This generalises the old rule that the top select code maps to the last input.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Latency is 1 cycle: a beat accepted at edge k appears on out_data at edge k.
- Buffer: main register (drives outputs) plus skid register. State enum EMPTY / ONE / FULL.
  - in_ready = (state != FULL). Decoded from registered state only; no combinational path from out_ready.
  - out_valid = (state != EMPTY).
- EMPTY:
  - Input transfer: load main, go to ONE.
  - Otherwise stay in EMPTY.
- ONE:
  - Input and output transfer together: load main with the new beat, stay in ONE. Full throughput.
  - Output transfer only: go to EMPTY.
  - Input transfer only: load skid, go to FULL.
  - Neither: hold.
- FULL:
  - No input accepted.
  - Output transfer: move skid to main, go to ONE.
  - Otherwise hold both entries.
- Data ordering: strictly FIFO. out_data and out_sel_err stay stable while out_valid & !out_ready.
- err_cnt:
  - Increments by 1 on each input transfer with sel_err set; saturates at 2^ERR_CNT_W-1.
  - err_cnt_clr has priority over increment in the same cycle; result is 0.
- Reset asserted mid-operation: buffered beats are discarded, with no output beat produced. The first cycle after deassertion behaves as EMPTY.
- in_valid is allowed to drop without a transfer. The block does not require upstream to hold its offer.

Decomposition:
- Package muxn_pkg holds:
  - typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;
  - a localparam for the maximum NUM_IN (16).
- One sub-module: muxn_sel, a purely combinational N:1 selector with clamp and sel_err output (parameters WIDTH, NUM_IN).
- muxn_pipe instantiates muxn_sel once and implements the buffer FSM and the counter.

Test Plan:
- Reset, then NUM_IN=3, in_sel=1, in_data={d2=0xCCCC0003, d1=0xBBBB0002, d0=0xAAAA0001}, out_ready=1 -> next cycle out_valid=1, out_data=0xBBBB0002, out_sel_err=0.
- in_sel=3 with NUM_IN=3 -> out_data=d2=0xCCCC0003, out_sel_err=1, err_cnt 0->1. Then err_cnt_clr=1 together with another in_sel=3 beat -> err_cnt=0.
- Stream 8 beats with out_ready=1 every cycle -> in_ready stays 1, one beat out per cycle, order preserved, 1-cycle latency.
- Hold out_ready=0 and offer 3 beats A,B,C -> A and B accepted, in_ready=0 in FULL, C held upstream, out_data=A stable. Release out_ready -> output order A,B,C.
- Drive 300 sel-error beats with ERR_CNT_W=8 -> err_cnt saturates at 255 and does not wrap.
- Assert rst_n low while in FULL -> outputs go to 0 immediately (asynchronous). After release, out_valid=0, in_ready=1, no stale beat emitted.

Source files
------------

// File: rtl/muxn_pkg.sv
// Shared types and limits for the parametrised result-select pipeline.
package muxn_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  localparam int unsigned MAX_NUM_IN = 16;

endpackage

// File: rtl/muxn_sel.sv
// Combinational N:1 selector; out-of-range selects clamp to the last input and flag sel_err_o.
module muxn_sel
  import muxn_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    sel_err_o
);

  logic [31:0] sel_ext;

  always_comb begin
    sel_ext   = 32'(sel_i);
    sel_err_o = (sel_ext >= NUM_IN);
    data_o    = in_data_i[(NUM_IN-1)*WIDTH +: WIDTH];
    for (int i = 0; i < int'(NUM_IN) - 1; i++) begin
      if (sel_ext == 32'(i)) begin
        data_o = in_data_i[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/muxn_pipe.sv
// N-input selector with a registered, valid/ready output stage backed by a 2-entry skid buffer
// and a saturating count of out-of-range selects.
module muxn_pipe
  import muxn_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_IN    = 3,
  parameter int unsigned SEL_W     = $clog2(NUM_IN),
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ERR_CNT_W-1:0]    err_cnt,
  input  logic                    err_cnt_clr
);

  buf_state_t           state_q, state_d;
  logic [WIDTH-1:0]     main_data_q, main_data_d;
  logic                 main_err_q, main_err_d;
  logic [WIDTH-1:0]     skid_data_q, skid_data_d;
  logic                 skid_err_q, skid_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic             in_xfer;
  logic             out_xfer;

  muxn_sel #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_sel (
    .in_data_i (in_data),
    .sel_i     (in_sel),
    .data_o    (sel_data),
    .sel_err_o (sel_err)
  );

  // Ready comes from registered state only, so out_ready never reaches in_ready combinationally.
  assign in_ready    = (state_q != FULL);
  assign out_valid   = (state_q != EMPTY);
  assign out_data    = main_data_q;
  assign out_sel_err = main_err_q;
  assign err_cnt     = err_cnt_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_err_d  = main_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_data_d = sel_data;
          main_err_d  = sel_err;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_data_d = sel_data;
          main_err_d  = sel_err;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end else if (in_xfer) begin
          skid_data_d = sel_data;
          skid_err_d  = sel_err;
          state_d     = FULL;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_data_d = skid_data_q;
          main_err_d  = skid_err_q;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr) begin
      err_cnt_d = '0;
    end else if (in_xfer && sel_err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_err_q  <= main_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

endmodule
